// File: rtl/line_drawing_control.sv
// Line drawing control FSM: sequences the datapath through setup,
// a four-cycle per-pixel plot loop, and a held completion state.
module line_drawing_control (
   input  logic clk,
   input  logic reset,
   input  logic start,
   input  logic steep,
   input  logic x0_gt_x1,
   input  logic x_lte_x1,
   output logic ld_initial,
   output logic ld_steep,
   output logic swap_1,
   output logic swap_2,
   output logic ld_delta_x,
   output logic ld_delta_y,
   output logic ld_y_step,
   output logic ld_err,
   output logic ld_y,
   output logic ld_x,
   output logic plot_EN,
   output logic incr_err,
   output logic incr_y,
   output logic decr_err,
   output logic incr_x,
   output logic update_x0_y0,
   output logic Done
);

   typedef enum logic [3:0] {
      ST_IDLE   = 4'd0,
      ST_LOAD   = 4'd1,
      ST_STEEP  = 4'd2,
      ST_SWAP1  = 4'd3,
      ST_SWAP2  = 4'd4,
      ST_DELTA  = 4'd5,
      ST_INIT   = 4'd6,
      ST_PLOT   = 4'd7,
      ST_ADJ    = 4'd8,
      ST_ADV    = 4'd9,
      ST_CHECK  = 4'd10,
      ST_UPDATE = 4'd11,
      ST_DONE   = 4'd12
   } state_t;

   state_t r_state;
   state_t w_next;

   // State register; reset forces IDLE at once, even mid-line.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next state and state-decoded strobes; CHECK gives x one cycle to settle.
   always_comb begin
      w_next       = r_state;
      ld_initial   = 1'b0;
      ld_steep     = 1'b0;
      swap_1       = 1'b0;
      swap_2       = 1'b0;
      ld_delta_x   = 1'b0;
      ld_delta_y   = 1'b0;
      ld_y_step    = 1'b0;
      ld_err       = 1'b0;
      ld_y         = 1'b0;
      ld_x         = 1'b0;
      plot_EN      = 1'b0;
      incr_err     = 1'b0;
      incr_y       = 1'b0;
      decr_err     = 1'b0;
      incr_x       = 1'b0;
      update_x0_y0 = 1'b0;
      Done         = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (start) w_next = ST_LOAD;
         end
         ST_LOAD: begin
            ld_initial = 1'b1;
            w_next     = ST_STEEP;
         end
         ST_STEEP: begin
            ld_steep = 1'b1;
            w_next   = ST_SWAP1;
         end
         ST_SWAP1: begin
            swap_1 = steep;
            w_next = ST_SWAP2;
         end
         ST_SWAP2: begin
            swap_2 = x0_gt_x1;
            w_next = ST_DELTA;
         end
         ST_DELTA: begin
            ld_delta_x = 1'b1;
            ld_delta_y = 1'b1;
            ld_y_step  = 1'b1;
            w_next     = ST_INIT;
         end
         ST_INIT: begin
            ld_err = 1'b1;
            ld_y   = 1'b1;
            ld_x   = 1'b1;
            w_next = ST_PLOT;
         end
         ST_PLOT: begin
            plot_EN  = 1'b1;
            incr_err = 1'b1;
            w_next   = ST_ADJ;
         end
         ST_ADJ: begin
            incr_y   = 1'b1;
            decr_err = 1'b1;
            w_next   = ST_ADV;
         end
         ST_ADV: begin
            incr_x = 1'b1;
            w_next = ST_CHECK;
         end
         ST_CHECK: begin
            w_next = x_lte_x1 ? ST_PLOT : ST_UPDATE;
         end
         ST_UPDATE: begin
            update_x0_y0 = 1'b1;
            w_next       = ST_DONE;
         end
         ST_DONE: begin
            Done = 1'b1;
            if (!start) w_next = ST_IDLE;
         end
         default: begin
            w_next = ST_IDLE;
         end
      endcase
   end

endmodule
